// File: rtl/rop_pkg.sv
// Shared types and constants for the random-word pool.
package rop_pkg;

    localparam int ROP_RNG_W  = 64;
    localparam int ROP_WORD_W = 32;

    typedef enum logic [1:0] {
        ROP_POOL_IDLE    = 2'd0,
        ROP_POOL_STIR    = 2'd1,
        ROP_POOL_CAPTURE = 2'd2
    } rop_pool_state_e;

    // Fold the 64-bit PRNG state into one 32-bit sample word.
    function automatic logic [ROP_WORD_W-1:0] rop_fold(input logic [ROP_RNG_W-1:0] r);
        return r[ROP_RNG_W-1:ROP_WORD_W] ^ r[ROP_WORD_W-1:0];
    endfunction

endpackage

// File: rtl/rop_prng.sv
// 64-bit Fibonacci LFSR (taps 64,63,61,60), shifting left. Advances when en_i is high.
module rop_prng
    import rop_pkg::*;
#(
    parameter logic [ROP_RNG_W-1:0] SEED = '1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 en_i,
    output logic [ROP_RNG_W-1:0] random_o
);

    logic [ROP_RNG_W-1:0] state_q;
    logic                 fb;

    assign fb       = state_q[63] ^ state_q[62] ^ state_q[60] ^ state_q[59];
    assign random_o = state_q;

    // Shift one step per enabled cycle; reset reloads the seed.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= SEED;
        end else if (en_i) begin
            state_q <= {state_q[ROP_RNG_W-2:0], fb};
        end
    end

endmodule

// File: rtl/rop_rng_fifo.sv
// First-word-fall-through FIFO: head word is read combinationally at the read pointer.
module rop_rng_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [W-1:0]             push_data_i,
    input  logic                     pop_i,
    output logic                     valid_o,
    output logic [W-1:0]             data_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [LW-1:0] level_q, level_d;
    logic          push_ok, pop_ok, full, empty;

    assign full    = (level_q == DEPTH_L);
    assign empty   = (level_q == '0);
    // A push into a full FIFO is dropped; flush overrides both sides.
    assign push_ok = push_i && !full && !flush_i;
    assign pop_ok  = pop_i && !empty && !flush_i;

    assign valid_o = !empty;
    assign data_o  = empty ? '0 : mem_q[rptr_q];
    assign level_o = level_q;

    // Level follows the accepted push/pop pair; simultaneous push and pop cancel.
    always_comb begin
        level_d = level_q;
        if (flush_i) begin
            level_d = '0;
        end else if (push_ok && !pop_ok) begin
            level_d = level_q + LW'(1);
        end else if (pop_ok && !push_ok) begin
            level_d = level_q - LW'(1);
        end
    end

    // Storage array is not reset; only the pointers and level define contents.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wptr_q] <= push_data_i;
        end
    end

    // Pointers wrap naturally modulo DEPTH since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!resetn || flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + AW'(1);
            if (pop_ok)  rptr_q <= rptr_q + AW'(1);
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/rop_rng_pool.sv
// Pool of decimated PRNG words: stir the PRNG DECIMATE times, fold, push into a FWFT FIFO.
module rop_rng_pool
    import rop_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int DECIMATE = 64
) (
    input  logic                      clk,
    input  logic                      resetn,
    output logic                      rng_en,
    input  logic [ROP_RNG_W-1:0]      rng_random,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ROP_WORD_W-1:0]     out_data,
    output logic [$clog2(DEPTH):0]    level
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
    localparam logic [7:0]    DEC_LOAD = 8'(DECIMATE - 1);

    rop_pool_state_e state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            rng_en_q;
    logic            push, pop, full;
    logic [LW-1:0]   post_level;

    assign push = (state_q == ROP_POOL_CAPTURE);
    assign pop  = out_valid && out_ready;
    assign full = (level == DEPTH_L);
    // Level after this cycle's push/pop, used to decide whether to keep filling.
    assign post_level = level + ((push && !full) ? LW'(1) : LW'(0))
                              - (pop ? LW'(1) : LW'(0));

    // The PRNG advances on the same edge; flush suppresses the advance immediately.
    assign rng_en = rng_en_q && !flush;

    rop_rng_fifo #(
        .DEPTH (DEPTH),
        .W     (ROP_WORD_W)
    ) u_fifo (
        .clk         (clk),
        .resetn      (resetn),
        .flush_i     (flush),
        .push_i      (push),
        .push_data_i (rop_fold(rng_random)),
        .pop_i       (pop),
        .valid_o     (out_valid),
        .data_o      (out_data),
        .level_o     (level)
    );

    // Fill sequencing: IDLE waits for room, STIR counts advances, CAPTURE pushes one word.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ROP_POOL_IDLE: begin
                if (level < DEPTH_L) begin
                    state_d = ROP_POOL_STIR;
                    cnt_d   = DEC_LOAD;
                end
            end
            ROP_POOL_STIR: begin
                if (cnt_q == 8'd0) state_d = ROP_POOL_CAPTURE;
                else               cnt_d   = cnt_q - 8'd1;
            end
            ROP_POOL_CAPTURE: begin
                if (post_level < DEPTH_L) begin
                    state_d = ROP_POOL_STIR;
                    cnt_d   = DEC_LOAD;
                end else begin
                    state_d = ROP_POOL_IDLE;
                end
            end
            default: state_d = ROP_POOL_IDLE;
        endcase
        if (flush) begin
            state_d = ROP_POOL_IDLE;
            cnt_d   = 8'd0;
        end
    end

    // State, counter and registered advance request.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= ROP_POOL_IDLE;
            cnt_q    <= 8'd0;
            rng_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rng_en_q <= (state_d == ROP_POOL_STIR);
        end
    end

endmodule

// File: tb/tb_rop_rng_pool.sv
// Directed bench: DUT1 with DECIMATE=1, DUT2 with DECIMATE=64, each fed by its own PRNG.
module tb_rop_rng_pool;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn1, flush1, ready1, en1, valid1;
    logic [63:0] rnd1;
    logic [31:0] data1;
    logic [2:0]  level1;

    logic        rstn2, flush2, ready2, en2, valid2;
    logic [63:0] rnd2;
    logic [31:0] data2;
    logic [2:0]  level2;

    int checks   = 0;
    int failures = 0;

    rop_prng u_prng1 (.clk(clk), .resetn(rstn1), .en_i(en1), .random_o(rnd1));
    rop_rng_pool #(.DEPTH(4), .DECIMATE(1)) u_dut1 (
        .clk(clk), .resetn(rstn1), .rng_en(en1), .rng_random(rnd1), .flush(flush1),
        .out_valid(valid1), .out_ready(ready1), .out_data(data1), .level(level1)
    );

    rop_prng u_prng2 (.clk(clk), .resetn(rstn2), .en_i(en2), .random_o(rnd2));
    rop_rng_pool #(.DEPTH(4), .DECIMATE(64)) u_dut2 (
        .clk(clk), .resetn(rstn2), .rng_en(en2), .rng_random(rnd2), .flush(flush2),
        .out_valid(valid2), .out_ready(ready2), .out_data(data2), .level(level2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end else begin
            $display("ok   %s value=%0h", name, act);
        end
    endtask

    typedef struct {
        logic        rng_en;
        logic        valid;
        logic [2:0]  level;
        logic [31:0] data;
    } vec_t;

    vec_t tbl [11];
    logic [31:0] drain_exp [4];
    int en_cnt;

    initial begin
        // Expected per-cycle view of DUT1 after reset release, out_ready held low.
        tbl[0]  = '{1'b0, 1'b0, 3'd0, 32'h0};
        tbl[1]  = '{1'b1, 1'b0, 3'd0, 32'h0};
        tbl[2]  = '{1'b0, 1'b0, 3'd0, 32'h0};
        tbl[3]  = '{1'b1, 1'b1, 3'd1, 32'h1};
        tbl[4]  = '{1'b0, 1'b1, 3'd1, 32'h1};
        tbl[5]  = '{1'b1, 1'b1, 3'd2, 32'h1};
        tbl[6]  = '{1'b0, 1'b1, 3'd2, 32'h1};
        tbl[7]  = '{1'b1, 1'b1, 3'd3, 32'h1};
        tbl[8]  = '{1'b0, 1'b1, 3'd3, 32'h1};
        tbl[9]  = '{1'b0, 1'b1, 3'd4, 32'h1};
        tbl[10] = '{1'b0, 1'b1, 3'd4, 32'h1};
        drain_exp[0] = 32'h3;
        drain_exp[1] = 32'h7;
        drain_exp[2] = 32'hF;
        drain_exp[3] = 32'h1F;

        rstn1 = 1'b0; flush1 = 1'b0; ready1 = 1'b0;
        rstn2 = 1'b0; flush2 = 1'b0; ready2 = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_rng_en1", en1, 0);
        chk("rst_valid1", valid1, 0);
        chk("rst_data1", data1, 0);
        chk("rst_level1", level1, 0);
        chk("rst_rng_en2", en2, 0);
        chk("rst_valid2", valid2, 0);

        // First words with DECIMATE=1
        rstn1 = 1'b1;
        for (int c = 0; c < 11; c++) begin
            if (c > 0) @(negedge clk);
            chk($sformatf("fill_c%0d_rng_en", c), en1, tbl[c].rng_en);
            chk($sformatf("fill_c%0d_valid", c), valid1, tbl[c].valid);
            chk($sformatf("fill_c%0d_level", c), level1, tbl[c].level);
            chk($sformatf("fill_c%0d_data", c), data1, tbl[c].data);
        end

        // Single pop from full, then refill of the freed slot
        ready1 = 1'b1;
        chk("pop_head", data1, 32'h1);
        @(negedge clk);                                   // c11
        ready1 = 1'b0;
        chk("pop_level", level1, 3);
        chk("pop_new_head", data1, 32'h3);
        chk("pop_idle_rng_en", en1, 0);
        @(negedge clk);                                   // c12
        chk("refill_stir", en1, 1);
        @(negedge clk);                                   // c13
        chk("refill_capture", en1, 0);
        chk("refill_level_pre", level1, 3);
        @(negedge clk);                                   // c14
        chk("refill_level", level1, 4);
        chk("refill_idle", en1, 0);
        ready1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain_%0d_valid", i), valid1, 1);
            chk($sformatf("drain_%0d_data", i), data1, drain_exp[i]);
            @(negedge clk);
        end
        ready1 = 1'b0;

        // Flush in a CAPTURE cycle with level 2
        rstn1 = 1'b0;
        repeat (2) @(negedge clk);
        rstn1 = 1'b1;
        repeat (6) @(negedge clk);                        // c6, CAPTURE
        chk("flush_pre_level", level1, 2);
        chk("flush_pre_capture", en1, 0);
        flush1 = 1'b1;
        @(negedge clk);                                   // c7
        flush1 = 1'b0;
        chk("flush_level", level1, 0);
        chk("flush_valid", valid1, 0);
        chk("flush_idle", en1, 0);
        @(negedge clk);                                   // c8
        chk("flush_restir", en1, 1);
        @(negedge clk);                                   // c9
        chk("flush_capture", en1, 0);
        @(negedge clk);                                   // c10
        chk("flush_post_level", level1, 1);
        chk("flush_post_data", data1, 32'hF);

        // Decimation count with DECIMATE=64
        rstn2 = 1'b1;
        en_cnt = 0;
        for (int c = 0; c <= 65; c++) begin
            if (c > 0) @(negedge clk);
            if (en2) en_cnt++;
            if (c == 65) chk("dec_c65_valid", valid2, 0);
        end
        @(negedge clk);                                   // c66
        chk("dec_c66_valid", valid2, 1);
        chk("dec_c66_level", level2, 1);
        chk("dec_first_en_count", en_cnt, 64);
        en_cnt = 0;
        for (int c = 66; c <= 130; c++) begin
            if (c > 66) @(negedge clk);
            if (en2) en_cnt++;
        end
        @(negedge clk);                                   // c131
        chk("dec_second_en_count", en_cnt, 64);
        chk("dec_c131_level", level2, 2);

        // Reset in STIR cycle 10
        rstn2 = 1'b0;
        repeat (2) @(negedge clk);
        rstn2 = 1'b1;
        repeat (10) @(negedge clk);                       // c10
        chk("midrst_stir", en2, 1);
        rstn2 = 1'b0;
        @(negedge clk);
        chk("midrst_rng_en", en2, 0);
        chk("midrst_valid", valid2, 0);
        chk("midrst_level", level2, 0);
        chk("midrst_data", data2, 0);
        rstn2 = 1'b1;
        @(negedge clk);                                   // c1 after re-release
        chk("midrst_restart", en2, 1);
        chk("midrst_restart_level", level2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rop_rng_pool.md
# rop_rng_pool

Downstream consumer of the LFSR PRNG. It steps the PRNG through a run of advances, then folds the resulting 64-bit state into a 32-bit word. The words go into a small first-word-fall-through FIFO that the coprocessor's random-sample instruction drains over a valid/ready handshake. Decimation hides the one-bit-shift correlation between consecutive LFSR states, and buffering keeps sample latency at one cycle while the pool is non-empty.

## Interface
- `DEPTH`, default 4: FIFO entries. Power of two, at least 2.
- `DECIMATE`, default 64: PRNG advances per captured word, from 1 to 255.
- `clk`  in  1  global clock.
- `resetn`  in  1  reset, synchronous, active-low.
- `rng_en`  out  1  advance request to the PRNG. The PRNG advances on the same edge.
- `rng_random`  in  64  current PRNG state.
- `flush`  in  1  synchronous clear of pool contents and the fill sequence.
- `out_valid`  out  1  the FIFO head is valid.
- `out_ready`  in  1  the consumer accepts the head.
- `out_data`  out  32  the FIFO head word.
- `level`  out  `$clog2(DEPTH)+1`  current number of stored words.

## Operation
- Fill FSM states: IDLE, STIR, CAPTURE.
- **IDLE:** go to STIR next cycle when `level < DEPTH`.
- **STIR:** `rng_en`=1 every cycle. The down-counter loads `DECIMATE-1` on entry. When the count reaches 0, go to CAPTURE.
- **CAPTURE:** `rng_en`=0.
  - Push `rng_random[63:32] ^ rng_random[31:0]`.
  - Next state is STIR if the post-update level is below `DEPTH`, else IDLE.
- Pop when `out_valid && out_ready`. `out_data` is the oldest word.
- A pop and a push in the same cycle are both performed, and `level` is unchanged.
- The FSM never pushes into a full FIFO. If one were attempted, it is dropped and `level` is unchanged.
- No bypass: a word pushed into an empty FIFO is visible one cycle later.
- `flush` takes priority over push, pop and every FSM transition:
  - `level`←0, FSM←IDLE, counter cleared, `rng_en`=0 in the flush cycle.
  - A capture that coincides with flush is discarded.
- Reset mid-STIR aborts the sequence with no push.
- The PRNG keeps its state across `flush`; only this block's state clears.
- Read and write pointers are `log2(DEPTH)` bits wide and wrap modulo `DEPTH`. `level` saturates logically at `DEPTH` because of the no-push-when-full rule.

## Timing
- Reset values:
  - `rng_en`=0, `out_valid`=0, `out_data`=0, `level`=0.
  - State IDLE, pointers 0, counter 0.
- Cycle 0 is the first cycle with `resetn`=1:
  - Cycle 0: IDLE.
  - Cycles 1 to `DECIMATE`: STIR.
  - Cycle `DECIMATE+1`: CAPTURE.
  - `out_valid`=1 from cycle `DECIMATE+2`.
- Steady-state fill rate is one word per `DECIMATE+1` cycles.
- Pop-to-`out_valid` update takes one cycle (registered `level`/pointers). The head data is combinational from the RAM at the read pointer.
- Refill after the pool drains from full resumes at the CAPTURE→STIR or IDLE→STIR edge. It does not wait for empty.
- `out_data` is held stable while `out_valid && !out_ready`.

## Structure
- Shared package `rop_pkg`:
  - FSM state encoding `ROP_POOL_IDLE`/`STIR`/`CAPTURE` (2-bit).
  - `ROP_RNG_W`=64 and `ROP_WORD_W`=32 constants.
- One sub-module, `rop_rng_fifo`: a parameterised FWFT FIFO with push/pop/flush/level.
- The FSM, decimation counter and fold logic live in `rop_rng_pool`.
- The bench instantiates `rop_prng` with its default all-ones seed and connects `rng_en`/`rng_random`.

## Test plan
- **Reset values:** reset for 3 cycles, then hold `out_ready`=0. Expect every output at its reset value during reset, `rng_en` low in cycle 0, and `rng_en` high in cycle 1.
- **First words, `DECIMATE`=1, `DEPTH`=4, `out_ready`=0:**
  - `out_valid` rises in cycle 3.
  - Words are 0x00000001, 0x00000003, 0x00000007 and 0x0000000F.
  - `level` reaches 4; the FSM then sits in IDLE with `rng_en`=0.
- **Full pool, drain:** from full, set `out_ready`=1 for one cycle. Expect pop of 0x00000001, `level` 3, and STIR restarting the next cycle. The new tail word is 0x0000001F.
- **Decimation count, `DECIMATE`=64:** count `rng_en`-high cycles between consecutive pushes. Expect exactly 64, and the first `out_valid` at cycle 66.
- **Flush:** assert `flush` in a CAPTURE cycle while `level`=2. Expect no push, `level` 0 and `out_valid` 0 the next cycle, and IDLE→STIR one cycle later.
- **Reset mid-STIR:** drop `resetn` in STIR cycle 10. Expect all outputs back at reset values the next cycle, and no word pushed.
